mkds_second_half: RTL and testbench

Downstream stage of the MKDS strobe decoder. It consumes the 16 one-hot register strobes and 4 direction strobes produced by the first half, together with the same 16-bit command bus. It holds a 16 x 8-bit register bank (128 bits) and returns contents on an 8-bit read-back port (128-to-8 mux) under a valid/ready handshake, supporting single and burst reads.

---
 rtl/mkds_second_half.sv | 147 ++++++++++++++
 tb/tb_mkds_second_half.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mkds_second_half.sv
// MKDS strobe decoder, downstream half: 16x8 register bank with a single/burst read-back port.
// Optional feature macro: MKDS_ONEHOT_CHECK_EN (multi-hot strobe detection with sticky err).
module mkds_second_half #(
  parameter int DATA_W = 8,
  parameter int NREG   = 16,
  parameter int PTR_W  = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [15:0]       data_in,
  input  logic [NREG-1:0]   strob_in_reg,
  input  logic [3:0]        strob_in_dir,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] bank_q [NREG];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  count_q;
  logic [NREG-1:0]   regPrev_q;
  logic [3:0]        dirPrev_q;
  logic [DATA_W-1:0] dataOut_q;
  logic              dataValid_q;
  logic              err_q;

  logic [NREG-1:0]   regRise;
  logic [3:0]        dirRise;
  logic              writeEn;
  logic [PTR_W-1:0]  writeIdx;
  logic [PTR_W-1:0]  ptr_d;
  logic [PTR_W-1:0]  count_d;
  logic              unusedBits;

  assign regRise = strob_in_reg & ~regPrev_q;
  assign dirRise = strob_in_dir & ~dirPrev_q;
  assign ptr_d   = ptr_q + PTR_W'(1);
  assign count_d = count_q + PTR_W'(1);
  assign unusedBits = ^data_in[15:DATA_W];

`ifdef MKDS_ONEHOT_CHECK_EN
  logic regMulti;
  logic dirMulti;
  // x & (x-1) is nonzero exactly when more than one bit is set
  assign regMulti = |(regRise & (regRise - NREG'(1)));
  assign dirMulti = |(dirRise & (dirRise - 4'd1));
`endif

  // Lowest rising register strobe selects the bank entry to write
  always_comb begin
    writeEn  = |regRise;
    writeIdx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (regRise[i]) writeIdx = PTR_W'(i);
    end
`ifdef MKDS_ONEHOT_CHECK_EN
    if (regMulti) writeEn = 1'b0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      regPrev_q   <= '0;
      dirPrev_q   <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else begin
      regPrev_q <= strob_in_reg;
      dirPrev_q <= strob_in_dir;
      if (dirRise[3]) begin
        // Clear outranks everything, including a same-cycle register write
        state_q     <= IDLE;
        ptr_q       <= '0;
        count_q     <= '0;
        dataOut_q   <= '0;
        dataValid_q <= 1'b0;
        err_q       <= 1'b0;
        for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
      end else begin
        if (writeEn) bank_q[writeIdx] <= data_in[DATA_W-1:0];
`ifdef MKDS_ONEHOT_CHECK_EN
        if (regMulti || dirMulti) err_q <= 1'b1;
`endif
        case (state_q)
          IDLE: begin
            if (dirRise[0]) begin
              ptr_q <= data_in[PTR_W-1:0];
            end else if (dirRise[1]) begin
              dataOut_q   <= bank_q[ptr_q];
              dataValid_q <= 1'b1;
              state_q     <= SINGLE;
            end else if (dirRise[2]) begin
              dataOut_q   <= bank_q[ptr_q];
              dataValid_q <= 1'b1;
              count_q     <= '0;
              state_q     <= BURST;
            end
          end
          SINGLE: begin
            if (rd_ready) begin
              dataValid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
          BURST: begin
            // Pointer walks a full lap, so it lands back on its start value
            if (rd_ready) begin
              ptr_q   <= ptr_d;
              count_q <= count_d;
              if (count_q == PTR_W'(NREG - 1)) begin
                dataValid_q <= 1'b0;
                state_q     <= IDLE;
              end else begin
                dataOut_q <= bank_q[ptr_d];
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out   = dataOut_q;
  assign data_valid = dataValid_q;
  assign busy       = (state_q != IDLE);
`ifdef MKDS_ONEHOT_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mkds_second_half.sv
// Scoreboard testbench for mkds_second_half: expected beats are queued when a read
// is issued and popped by a monitor on every accepted beat.
module tb_mkds_second_half;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [15:0] data_in;
  logic [15:0] strob_in_reg;
  logic [3:0]  strob_in_dir;
  logic        rd_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        err;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  expQ[$];
  logic [7:0]  modelBank[16];
  int          modelPtr;
  bit          randReady = 1'b0;
  logic [7:0]  monExp;

  mkds_second_half dut (
    .CLK(CLK),
    .CLR(CLR),
    .data_in(data_in),
    .strob_in_reg(strob_in_reg),
    .strob_in_dir(strob_in_dir),
    .rd_ready(rd_ready),
    .data_out(data_out),
    .data_valid(data_valid),
    .busy(busy),
    .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every beat accepted at the coming edge must match the head of the queue
  always @(negedge CLK) begin
    if (!CLR && data_valid && rd_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected beat: got 0x%0h, expected no beat", data_out);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("beat data", {24'd0, data_out}, {24'd0, monExp});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (randReady) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [15:0] regS, input logic [3:0] dirS, input logic [15:0] dataS);
    strob_in_reg = regS;
    strob_in_dir = dirS;
    data_in      = dataS;
    tick();
  endtask

  // Only the first cycle of a held strobe may write; later cycles carry junk data
  task automatic writeReg(input int idx, input logic [7:0] data, input int hold);
    applyStimulus(16'd1 << idx, 4'd0, {8'd0, data});
    for (int h = 1; h < hold; h++) applyStimulus(16'd1 << idx, 4'd0, 16'($urandom));
    applyStimulus(16'd0, 4'd0, {8'd0, data});
    modelBank[idx] = data;
  endtask

  task automatic pulseDir(input int dirBit, input logic [15:0] data);
    applyStimulus(16'd0, 4'd1 << dirBit, data);
    applyStimulus(16'd0, 4'd0, data);
  endtask

  task automatic loadPtr(input int p);
    pulseDir(0, 16'(p));
    modelPtr = p;
  endtask

  task automatic issueRead1();
    expQ.push_back(modelBank[modelPtr]);
    pulseDir(1, 16'd0);
  endtask

  task automatic pushBurst();
    for (int k = 0; k < 16; k++) expQ.push_back(modelBank[(modelPtr + k) % 16]);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) modelBank[i] = 8'h00;
    modelPtr = 0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || data_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: got busy=%0b, expected idle", name, busy);
    end
  endtask

  initial begin
    CLR = 1'b1;
    data_in = '0;
    strob_in_reg = '0;
    strob_in_dir = '0;
    rd_ready = 1'b0;
    clearModel();
    tick();
    checkOutput("reset data_out", {24'd0, data_out}, 32'h0);
    checkOutput("reset data_valid", {31'd0, data_valid}, 32'h0);
    checkOutput("reset busy", {31'd0, busy}, 32'h0);
    checkOutput("reset err", {31'd0, err}, 32'h0);
    CLR = 1'b0;
    tick();

    // Held strobe writes once, then a single read with latency 1
    writeReg(3, 8'hA5, 3);
    loadPtr(3);
    rd_ready = 1'b1;
    expQ.push_back(8'hA5);
    strob_in_dir = 4'b0010;
    checkOutput("t1 valid before rise", {31'd0, data_valid}, 32'h0);
    applyStimulus(16'd0, 4'b0010, 16'd0);
    checkOutput("t1 valid after rise", {31'd0, data_valid}, 32'h1);
    checkOutput("t1 data_out", {24'd0, data_out}, 32'hA5);
    applyStimulus(16'd0, 4'd0, 16'd0);
    checkOutput("t1 valid one cycle", {31'd0, data_valid}, 32'h0);
    checkOutput("t1 busy after", {31'd0, busy}, 32'h0);

    // Backpressure with a write to the presented register
    rd_ready = 1'b0;
    expQ.push_back(modelBank[3]);
    applyStimulus(16'd0, 4'b0010, 16'd0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp valid held", {31'd0, data_valid}, 32'h1);
      checkOutput("bp data frozen", {24'd0, data_out}, 32'hA5);
      checkOutput("bp busy", {31'd0, busy}, 32'h1);
      applyStimulus((c == 1) ? 16'h0008 : 16'h0000, 4'd0, 16'h0011);
    end
    modelBank[3] = 8'h11;
    rd_ready = 1'b1;
    checkOutput("bp data at accept", {24'd0, data_out}, 32'hA5);
    tick();
    checkOutput("bp valid after accept", {31'd0, data_valid}, 32'h0);
    checkOutput("bp busy after accept", {31'd0, busy}, 32'h0);
    issueRead1();
    waitIdle("bp reread");

    // Burst wrapping from pointer 14 with no gaps
    for (int i = 0; i < 16; i++) writeReg(i, 8'(i + 16), 1);
    loadPtr(14);
    rd_ready = 1'b1;
    pushBurst();
    applyStimulus(16'd0, 4'b0100, 16'd0);
    for (int k = 0; k < 16; k++) begin
      checkOutput("burst gapless valid", {31'd0, data_valid}, 32'h1);
      applyStimulus(16'd0, 4'd0, 16'd0);
    end
    checkOutput("burst end valid", {31'd0, data_valid}, 32'h0);
    checkOutput("burst end busy", {31'd0, busy}, 32'h0);
    issueRead1();
    waitIdle("burst ptr restore");

    // Pointer load and single read are ignored while a burst runs
    pushBurst();
    applyStimulus(16'd0, 4'b0100, 16'd0);
    applyStimulus(16'd0, 4'b0000, 16'd5);
    applyStimulus(16'd0, 4'b0001, 16'd5);
    applyStimulus(16'd0, 4'b0000, 16'd5);
    applyStimulus(16'd0, 4'b0010, 16'd0);
    applyStimulus(16'd0, 4'b0000, 16'd0);
    waitIdle("ignored cmds burst");
    issueRead1();
    waitIdle("ignored cmds ptr");

    // Abort after three accepted beats
    loadPtr(2);
    for (int k = 0; k < 3; k++) expQ.push_back(modelBank[2 + k]);
    applyStimulus(16'd0, 4'b0100, 16'd0);
    applyStimulus(16'd0, 4'd0, 16'd0);
    applyStimulus(16'd0, 4'd0, 16'd0);
    applyStimulus(16'd0, 4'd0, 16'd0);
    rd_ready = 1'b0;
    applyStimulus(16'd0, 4'b1000, 16'd0);
    clearModel();
    checkOutput("abort valid", {31'd0, data_valid}, 32'h0);
    checkOutput("abort busy", {31'd0, busy}, 32'h0);
    applyStimulus(16'd0, 4'd0, 16'd0);
    rd_ready = 1'b1;
    writeReg(0, 8'h3C, 1);
    pushBurst();
    pulseDir(2, 16'd0);
    waitIdle("abort readback");

    // Multi-hot register and direction strobes
    writeReg(6, 8'h66, 1);
    writeReg(7, 8'h71, 1);
    applyStimulus(16'h0041, 4'd0, 16'h0077);
    applyStimulus(16'd0, 4'd0, 16'h0077);
`ifdef MKDS_ONEHOT_CHECK_EN
    checkOutput("multihot err", {31'd0, err}, 32'h1);
`else
    modelBank[0] = 8'h77;
    checkOutput("multihot err", {31'd0, err}, 32'h0);
`endif
    applyStimulus(16'd0, 4'b0011, 16'd7);
    applyStimulus(16'd0, 4'd0, 16'd7);
    modelPtr = 7;
    issueRead1();
    waitIdle("multi dir read");
    loadPtr(0);
    pushBurst();
    pulseDir(2, 16'd0);
    waitIdle("multihot readback");
    pulseDir(3, 16'd0);
    clearModel();
    checkOutput("err cleared", {31'd0, err}, 32'h0);

    // Randomized traffic with random consumer backpressure
    randReady = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: writeReg($urandom_range(0, 15), 8'($urandom), $urandom_range(1, 3));
        5, 6: loadPtr($urandom_range(0, 15));
        7: begin
          issueRead1();
          waitIdle("rand read1");
        end
        8: begin
          pushBurst();
          pulseDir(2, 16'd0);
          waitIdle("rand burst");
        end
        default: tick();
      endcase
    end
    randReady = 1'b0;
    rd_ready = 1'b1;
    waitIdle("final drain");
    tick();
    checkOutput("queue drained", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
